// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory load/store unit.
//   - size codes for req_size_i
//   - lsu FSM state encoding
//   - misaligned(): flags reserved sizes and addresses not aligned to the access size
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      StIdle,
      StRead,
      StWrite,
      StResp
   } lsu_state_e;

   // 1 when the request cannot be performed: reserved size, odd half, or unaligned word.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addr_lo[0];
         SZ_WORD: bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_lane_mux.sv
// dmem_lane_mux: combinational lane steering for the load/store unit.
//   rdword_i     word read from the cache
//   size_i       access size code
//   addr_lo_i    byte offset within the word
//   unsigned_i   1 = zero-extend loads, 0 = sign-extend
//   wdata_i      right-aligned store data
//   load_data_o  selected lane shifted to bit 0 and extended to 32 bits
//   store_word_o rdword_i with the target lane(s) replaced (wdata_i for word stores)
module dmem_lane_mux
   import dmem_pkg::*;
(
   input  logic [31:0] rdword_i,
   input  logic [1:0]  size_i,
   input  logic [1:0]  addr_lo_i,
   input  logic        unsigned_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_data_o,
   output logic [31:0] store_word_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'h00;
      case (addr_lo_i)
         2'd0:    byte_sel = rdword_i[7:0];
         2'd1:    byte_sel = rdword_i[15:8];
         2'd2:    byte_sel = rdword_i[23:16];
         default: byte_sel = rdword_i[31:24];
      endcase
      half_sel = addr_lo_i[1] ? rdword_i[31:16] : rdword_i[15:0];

      case (size_i)
         SZ_BYTE: load_data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
         SZ_HALF: load_data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
         default: load_data_o = rdword_i;
      endcase

      store_word_o = rdword_i;
      case (size_i)
         SZ_BYTE: begin
            case (addr_lo_i)
               2'd0:    store_word_o[7:0]   = wdata_i[7:0];
               2'd1:    store_word_o[15:8]  = wdata_i[7:0];
               2'd2:    store_word_o[23:16] = wdata_i[7:0];
               default: store_word_o[31:24] = wdata_i[7:0];
            endcase
         end
         SZ_HALF: begin
            if (addr_lo_i[1]) store_word_o[31:16] = wdata_i[15:0];
            else              store_word_o[15:0]  = wdata_i[15:0];
         end
         default: store_word_o = wdata_i;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store initiator between the memory stage and the data cache.
//   req_*  one CPU request at a time over valid/ready; captured on accept
//   rsp_*  one-cycle completion pulse with load data and error flag
//   mem_*  word-addressed cache port; sub-word stores use read-modify-write
// All outputs are decoded from registered state only.
module dmem_lsu
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W = 6
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_unsigned_i,
   input  logic [ADDR_W+1:0] req_addr_i,
   input  logic [31:0]       req_wdata_i,
   output logic              rsp_valid_o,
   output logic [31:0]       rsp_rdata_o,
   output logic              rsp_err_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_dato_o,
   output logic              mem_write_o,
   output logic              mem_read_o,
   input  logic [31:0]       mem_dato_i
);

   lsu_state_e        state_q, state_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [ADDR_W+1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdword_q, rdword_d;
   logic              err_q, err_d;

   logic [31:0]       load_data;
   logic [31:0]       store_word;

   dmem_lane_mux u_lane_mux (
      .rdword_i     (rdword_q),
      .size_i       (size_q),
      .addr_lo_i    (addr_q[1:0]),
      .unsigned_i   (uns_q),
      .wdata_i      (wdata_q),
      .load_data_o  (load_data),
      .store_word_o (store_word)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         we_q     <= 1'b0;
         size_q   <= SZ_BYTE;
         uns_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdword_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         size_q   <= size_d;
         uns_q    <= uns_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdword_q <= rdword_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      size_d   = size_q;
      uns_d    = uns_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdword_d = rdword_q;
      err_d    = err_q;

      unique case (state_q)
         StIdle: begin
            if (req_valid_i) begin
               we_d    = req_we_i;
               size_d  = req_size_i;
               uns_d   = req_unsigned_i;
               addr_d  = req_addr_i;
               wdata_d = req_wdata_i;
               err_d   = misaligned(req_size_i, req_addr_i[1:0]);
               if (err_d)                       state_d = StResp;
               else if (!req_we_i)              state_d = StRead;
               else if (req_size_i == SZ_WORD)  state_d = StWrite;
               else                             state_d = StRead;  // RMW: fetch the word first
            end
         end
         StRead: begin
            rdword_d = mem_dato_i;
            state_d  = we_q ? StWrite : StResp;
         end
         StWrite: state_d = StResp;
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      req_ready_o = (state_q == StIdle);
      mem_read_o  = (state_q == StRead);
      mem_write_o = (state_q == StWrite);
      mem_addr_o  = (mem_read_o || mem_write_o) ? addr_q[ADDR_W+1:2] : '0;
      mem_dato_o  = mem_write_o ? store_word : 32'h0;
      rsp_valid_o = (state_q == StResp);
      rsp_err_o   = rsp_valid_o & err_q;
      rsp_rdata_o = (rsp_valid_o && !we_q && !err_q) ? load_data : 32'h0;
   end

endmodule
